// File: rtl/pong_pkg.sv
// Shared constants and types for the pong display path: VGA 640x480@60 timing,
// sprite geometry, colours and a clip-safe span test.
package pong_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned PADDLE_WIDTH  = 5;
  localparam int unsigned PADDLE_HEIGHT = 60;
  localparam int unsigned BALL_SIDE     = 8;
  localparam int unsigned SCREEN_BORDER = 10;

  localparam int unsigned X_POS_W = 10;
  localparam int unsigned Y_POS_W = 10;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned SPAN_W  = 11;

  typedef logic [11:0] rgb_t;

  localparam rgb_t COL_BALL   = 12'hFFF;
  localparam rgb_t COL_PADDLE = 12'hFFF;
  localparam rgb_t COL_BORDER = 12'h888;
  localparam rgb_t COL_NET    = 12'h444;
  localparam rgb_t COL_BG     = 12'h000;

  // One extra bit keeps lo+len from wrapping, so sprites near the edge clip instead.
  function automatic logic in_span(input logic [SPAN_W-1:0] pos, input logic [SPAN_W-1:0] lo,
                                   input logic [SPAN_W-1:0] len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters and raw (unpipelined) sync, active-area and new-frame decode.
module vga_timing #(
  parameter int unsigned H_ACTIVE = pong_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = pong_pkg::H_FP,
  parameter int unsigned H_SYNC   = pong_pkg::H_SYNC,
  parameter int unsigned H_BP     = pong_pkg::H_BP,
  parameter int unsigned V_ACTIVE = pong_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = pong_pkg::V_FP,
  parameter int unsigned V_SYNC   = pong_pkg::V_SYNC,
  parameter int unsigned V_BP     = pong_pkg::V_BP
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic [pong_pkg::CNT_W-1:0]   h_cnt,
  output logic [pong_pkg::CNT_W-1:0]   v_cnt,
  output logic                         active,
  output logic                         hsync_raw,
  output logic                         vsync_raw,
  output logic                         new_frame
);
  import pong_pkg::*;

  localparam logic [CNT_W-1:0] HLast      = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] VLast      = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] HActive    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VActive    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncStart = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSyncEnd   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VSyncStart = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSyncEnd   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    h_d = h_q + CNT_W'(1);
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + CNT_W'(1);
    end
  end

  assign h_cnt     = h_q;
  assign v_cnt     = v_q;
  assign active    = (h_q < HActive) && (v_q < VActive);
  assign hsync_raw = !((h_q >= HSyncStart) && (h_q < HSyncEnd));
  assign vsync_raw = !((v_q >= VSyncStart) && (v_q < VSyncEnd));
  assign new_frame = (h_q == '0) && (v_q == VActive);

endmodule

// File: rtl/frame_renderer.sv
// Display end of the game-state interface: snapshots sprite positions once per frame
// and rasterises them through a two-stage pipeline aligned with the sync outputs.
module frame_renderer #(
  parameter int unsigned H_ACTIVE      = pong_pkg::H_ACTIVE,
  parameter int unsigned H_FP          = pong_pkg::H_FP,
  parameter int unsigned H_SYNC        = pong_pkg::H_SYNC,
  parameter int unsigned H_BP          = pong_pkg::H_BP,
  parameter int unsigned V_ACTIVE      = pong_pkg::V_ACTIVE,
  parameter int unsigned V_FP          = pong_pkg::V_FP,
  parameter int unsigned V_SYNC        = pong_pkg::V_SYNC,
  parameter int unsigned V_BP          = pong_pkg::V_BP,
  parameter int unsigned PADDLE_WIDTH  = pong_pkg::PADDLE_WIDTH,
  parameter int unsigned PADDLE_HEIGHT = pong_pkg::PADDLE_HEIGHT,
  parameter int unsigned BALL_SIDE     = pong_pkg::BALL_SIDE,
  parameter int unsigned SCREEN_BORDER = pong_pkg::SCREEN_BORDER
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [pong_pkg::X_POS_W-1:0]  player_paddle_x_i,
  input  logic [pong_pkg::Y_POS_W-1:0]  player_paddle_y_i,
  input  logic [pong_pkg::X_POS_W-1:0]  pc_paddle_x_i,
  input  logic [pong_pkg::Y_POS_W-1:0]  pc_paddle_y_i,
  input  logic [pong_pkg::X_POS_W-1:0]  ball_x_i,
  input  logic [pong_pkg::Y_POS_W-1:0]  ball_y_i,
  output logic                          new_frame_o,
  output logic                          hsync_o,
  output logic                          vsync_o,
  output logic [11:0]                   rgb_o
);
  import pong_pkg::*;

  localparam logic [SPAN_W-1:0] BallLen  = SPAN_W'(BALL_SIDE);
  localparam logic [SPAN_W-1:0] PadW     = SPAN_W'(PADDLE_WIDTH);
  localparam logic [SPAN_W-1:0] PadH     = SPAN_W'(PADDLE_HEIGHT);
  localparam logic [CNT_W-1:0]  BordTop  = CNT_W'(SCREEN_BORDER);
  localparam logic [CNT_W-1:0]  BordBot  = CNT_W'(V_ACTIVE - SCREEN_BORDER);
  localparam logic [CNT_W-1:0]  NetLeft  = CNT_W'(H_ACTIVE / 2 - 1);
  localparam logic [CNT_W-1:0]  NetRight = CNT_W'(H_ACTIVE / 2);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active, hsync_raw, vsync_raw, new_frame;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .new_frame (new_frame)
  );

  assign new_frame_o = new_frame;

  // Snapshots: the raster only ever reads these, so mid-frame input changes cannot tear.
  logic [X_POS_W-1:0] pp_x_q, pc_x_q, ball_x_q;
  logic [Y_POS_W-1:0] pp_y_q, pc_y_q, ball_y_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pp_x_q   <= '0;
      pp_y_q   <= '0;
      pc_x_q   <= '0;
      pc_y_q   <= '0;
      ball_x_q <= '0;
      ball_y_q <= '0;
    end else if (new_frame) begin
      pp_x_q   <= player_paddle_x_i;
      pp_y_q   <= player_paddle_y_i;
      pc_x_q   <= pc_paddle_x_i;
      pc_y_q   <= pc_paddle_y_i;
      ball_x_q <= ball_x_i;
      ball_y_q <= ball_y_i;
    end
  end

  logic [SPAN_W-1:0] h_ext, v_ext;
  logic              ball_hit, paddle_hit, border, net;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  assign ball_hit   = in_span(h_ext, {1'b0, ball_x_q}, BallLen) &&
                      in_span(v_ext, {1'b0, ball_y_q}, BallLen);
  assign paddle_hit = (in_span(h_ext, {1'b0, pp_x_q}, PadW) &&
                       in_span(v_ext, {1'b0, pp_y_q}, PadH)) ||
                      (in_span(h_ext, {1'b0, pc_x_q}, PadW) &&
                       in_span(v_ext, {1'b0, pc_y_q}, PadH));
  assign border     = (v_cnt < BordTop) || (v_cnt >= BordBot);
  assign net        = ((h_cnt == NetLeft) || (h_cnt == NetRight)) && !v_cnt[3];

  // Stage 1: registered hit flags and raw sync.
  logic ball_q, paddle_q, border_q, net_q, active_q, hsync1_q, vsync1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ball_q   <= 1'b0;
      paddle_q <= 1'b0;
      border_q <= 1'b0;
      net_q    <= 1'b0;
      active_q <= 1'b0;
      hsync1_q <= 1'b1;
      vsync1_q <= 1'b1;
    end else begin
      ball_q   <= ball_hit;
      paddle_q <= paddle_hit;
      border_q <= border;
      net_q    <= net;
      active_q <= active;
      hsync1_q <= hsync_raw;
      vsync1_q <= vsync_raw;
    end
  end

  rgb_t rgb_d;

  always_comb begin
    rgb_d = COL_BG;
    if (!active_q) begin
      rgb_d = COL_BG;
    end else if (ball_q) begin
      rgb_d = COL_BALL;
    end else if (paddle_q) begin
      rgb_d = COL_PADDLE;
    end else if (border_q) begin
      rgb_d = COL_BORDER;
    end else if (net_q) begin
      rgb_d = COL_NET;
    end
  end

  // Stage 2: registered pixel and sync, all aligned two cycles behind the counters.
  rgb_t rgb_q;
  logic hsync_q, vsync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rgb_q   <= COL_BG;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync1_q;
      vsync_q <= vsync1_q;
    end
  end

  assign rgb_o   = rgb_q;
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Scoreboard bench for frame_renderer with full horizontal timing and a shortened frame.
module tb_frame_renderer;

  localparam int VA = 28;
  localparam int VFP = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VT = VA + VFP + VS + VB;
  localparam int HT = 800;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [9:0] pp_x, pp_y, pc_x, pc_y, ball_x, ball_y;
  logic       new_frame_o, hsync_o, vsync_o;
  logic [11:0] rgb_o;

  always #5 clk = ~clk;

  frame_renderer #(
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VS),
    .V_BP     (VB)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .player_paddle_x_i (pp_x),
    .player_paddle_y_i (pp_y),
    .pc_paddle_x_i     (pc_x),
    .pc_paddle_y_i     (pc_y),
    .ball_x_i          (ball_x),
    .ball_y_i          (ball_y),
    .new_frame_o       (new_frame_o),
    .hsync_o           (hsync_o),
    .vsync_o           (vsync_o),
    .rgb_o             (rgb_o)
  );

  typedef struct {int h; int v; int cap; logic [13:0] exp;} entry_t;
  typedef struct {int cap; int h; int v; logic [11:0] rgb;} dir_t;

  entry_t sb[$];
  dir_t   dirs[$];
  int     n_checks = 0;
  int     n_fail = 0;

  int mh, mv, captures;
  int s_px, s_py, s_cx, s_cy, s_bx, s_by;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic in_box(int h, int v, int x, int y, int w, int ht);
    return (h >= x) && (h < x + w) && (v >= y) && (v < y + ht);
  endfunction

  function automatic logic [13:0] model_pix(int h, int v);
    logic        hs, vs;
    logic [11:0] c;
    hs = !(h >= 656 && h < 752);
    vs = !(v >= VA + VFP && v < VA + VFP + VS);
    if (!(h < 640 && v < VA))                        c = 12'h000;
    else if (in_box(h, v, s_bx, s_by, 8, 8))         c = 12'hFFF;
    else if (in_box(h, v, s_px, s_py, 5, 60) ||
             in_box(h, v, s_cx, s_cy, 5, 60))        c = 12'hFFF;
    else if (v < 10 || v >= VA - 10)                 c = 12'h888;
    else if ((h == 319 || h == 320) && ((v >> 3) & 1) == 0) c = 12'h444;
    else                                             c = 12'h000;
    return {hs, vs, c};
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0;
    s_px = 0; s_py = 0; s_cx = 0; s_cy = 0; s_bx = 0; s_by = 0;
    sb.delete();
    repeat (2) sb.push_back('{h: -1, v: -1, cap: -1, exp: 14'h3000});
  endtask

  initial begin
    entry_t e;
    int     step, first_nf, last_nf, hs_fall, vs_fall;
    bit     post, hs_seen, hs_done, vs_seen, vs_done;
    logic   hs_prev, vs_prev;

    // Frame 1: ball (318,5) over border and net; frame 2: ball off-screen at x=1020.
    dirs.push_back('{cap: 1, h: 318, v: 5,  rgb: 12'hFFF});
    dirs.push_back('{cap: 1, h: 320, v: 5,  rgb: 12'hFFF});
    dirs.push_back('{cap: 1, h: 326, v: 5,  rgb: 12'h888});
    dirs.push_back('{cap: 1, h: 325, v: 12, rgb: 12'hFFF});
    dirs.push_back('{cap: 1, h: 325, v: 13, rgb: 12'h000});
    dirs.push_back('{cap: 1, h: 320, v: 16, rgb: 12'h444});
    dirs.push_back('{cap: 1, h: 0,   v: 15, rgb: 12'h000});
    dirs.push_back('{cap: 1, h: 22,  v: 15, rgb: 12'hFFF});
    dirs.push_back('{cap: 1, h: 25,  v: 15, rgb: 12'h000});
    dirs.push_back('{cap: 1, h: 617, v: 20, rgb: 12'hFFF});
    dirs.push_back('{cap: 2, h: 320, v: 8,  rgb: 12'h888});
    dirs.push_back('{cap: 2, h: 320, v: 5,  rgb: 12'h888});
    dirs.push_back('{cap: 2, h: 2,   v: 7,  rgb: 12'h888});
    dirs.push_back('{cap: 2, h: 2,   v: 12, rgb: 12'h000});
    dirs.push_back('{cap: 2, h: 320, v: 16, rgb: 12'h444});

    pp_x = 10'd20;  pp_y = 10'd2;
    pc_x = 10'd615; pc_y = 10'd20;
    ball_x = 10'd318; ball_y = 10'd5;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_hsync", 32'(hsync_o), 32'd1);
    check_eq("reset_vsync", 32'(vsync_o), 32'd1);
    check_eq("reset_rgb", 32'(rgb_o), 32'd0);
    check_eq("reset_new_frame", 32'(new_frame_o), 32'd0);
    #1 rst_ni = 1'b1;

    model_reset();
    captures = 0;
    step = 0; first_nf = -1; last_nf = -1; post = 0;
    hs_seen = 0; hs_done = 0; vs_seen = 0; vs_done = 0;
    hs_fall = 0; vs_fall = 0; hs_prev = 1'b1; vs_prev = 1'b1;

    forever begin
      check_eq("new_frame", 32'(new_frame_o), 32'(mh == 0 && mv == VA));
      if (new_frame_o && !post) begin
        if (first_nf < 0) begin
          first_nf = step;
          check_eq("first_frame", step, VA * HT);
        end else begin
          check_eq("frame_period", step - last_nf, VT * HT);
        end
        last_nf = step;
      end

      sb.push_back('{h: mh, v: mv, cap: captures, exp: model_pix(mh, mv)});
      if (sb.size() >= 3) begin
        e = sb.pop_front();
        check_eq("pixel", 32'({hsync_o, vsync_o, rgb_o}), 32'(e.exp));
        foreach (dirs[i]) begin
          if (dirs[i].cap == e.cap && dirs[i].h == e.h && dirs[i].v == e.v)
            check_eq("directed_rgb", 32'(rgb_o), 32'(dirs[i].rgb));
        end
      end

      if (hs_prev && !hsync_o && !hs_seen) begin
        hs_seen = 1; hs_fall = step;
        check_eq(post ? "restart_hsync_start" : "hsync_start", step, 658);
      end
      if (!hs_prev && hsync_o && hs_seen && !hs_done) begin
        hs_done = 1;
        check_eq("hsync_width", step - hs_fall, 96);
      end
      if (!post && vs_prev && !vsync_o && !vs_seen) begin
        vs_seen = 1; vs_fall = step;
        check_eq("vsync_start", step, (VA + VFP) * HT + 2);
      end
      if (!post && !vs_prev && vsync_o && vs_seen && !vs_done) begin
        vs_done = 1;
        check_eq("vsync_width", step - vs_fall, VS * HT);
      end
      hs_prev = hsync_o;
      vs_prev = vsync_o;

      // Input change mid-frame: must not appear until the next snapshot.
      if (captures == 1 && mh == 0 && mv == 3) ball_x = 10'd1020;

      if (!post && captures == 3 && mh == 400 && mv == VA + 1) begin
        rst_ni = 1'b0;
        #1;
        check_eq("midline_reset_hsync", 32'(hsync_o), 32'd1);
        check_eq("midline_reset_vsync", 32'(vsync_o), 32'd1);
        check_eq("midline_reset_rgb", 32'(rgb_o), 32'd0);
        check_eq("midline_reset_new_frame", 32'(new_frame_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_ni = 1'b1;
        model_reset();
        captures = 10;
        post = 1; step = 0;
        hs_seen = 0; hs_done = 0; hs_prev = 1'b1; vs_prev = 1'b1;
        continue;
      end

      if (post && step == 1700) break;

      @(posedge clk);
      if (mh == 0 && mv == VA) begin
        s_px = int'(pp_x); s_py = int'(pp_y);
        s_cx = int'(pc_x); s_cy = int'(pc_y);
        s_bx = int'(ball_x); s_by = int'(ball_y);
        captures++;
      end
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      #1;
      step++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
